// File: rtl/lfsr_checker.sv
`default_nettype none
// ============================================================================
// lfsr_checker : serial PRBS checker with a self-seeding reference LFSR
// Revision     : 1.0
// ============================================================================
module lfsr_checker #(
  parameter int               WIDTH       = 5,
  parameter logic [WIDTH-1:0] TAPS        = 5'b10100,
  parameter int               LOSS_THRESH = 4,
  parameter int               CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count
);

  localparam int SC_W = $clog2(WIDTH);

  typedef enum logic [0:0] {
    ST_SEED  = 1'b0,
    ST_CHECK = 1'b1
  } state_t;

  state_t           state_q,     state_d;
  logic [WIDTH-1:0] shadow_q,    shadow_d;
  logic [SC_W-1:0]  seed_cnt_q,  seed_cnt_d;
  logic [3:0]       miss_run_q,  miss_run_d;
  logic             locked_q,    locked_d;
  logic             err_q,       err_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic             fb;
  logic [WIDTH-1:0] seed_shift;

  assign fb         = ^(shadow_q & TAPS);
  assign seed_shift = {shadow_q[WIDTH-2:0], in_bit};

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    seed_cnt_d  = seed_cnt_q;
    miss_run_d  = miss_run_q;
    err_d       = 1'b0;
    err_count_d = err_count_q;

    if (in_valid) begin
      if (state_q == ST_SEED) begin
        shadow_d = seed_shift;
        if (seed_cnt_q == SC_W'(WIDTH - 1)) begin
          seed_cnt_d = '0;
          // An all-zero register is a dead LFSR state; keep seeding instead.
          if (seed_shift != '0) begin
            state_d = ST_CHECK;
          end
        end else begin
          seed_cnt_d = seed_cnt_q + 1'b1;
        end
      end else begin
        // Reference free-runs on its own prediction so one bad bit cannot corrupt it.
        shadow_d = {shadow_q[WIDTH-2:0], fb};
        if (in_bit != fb) begin
          err_d = 1'b1;
          if (err_count_q != '1) begin
            err_count_d = err_count_q + 1'b1;
          end
          if (miss_run_q == 4'(LOSS_THRESH - 1)) begin
            state_d    = ST_SEED;
            seed_cnt_d = '0;
            miss_run_d = '0;
          end else begin
            miss_run_d = miss_run_q + 1'b1;
          end
        end else begin
          miss_run_d = '0;
        end
      end
    end

    if (clr_cnt) begin
      err_count_d = '0;
    end

    locked_d = (state_d == ST_CHECK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SEED;
      shadow_q    <= '0;
      seed_cnt_q  <= '0;
      miss_run_q  <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      seed_cnt_q  <= seed_cnt_d;
      miss_run_q  <= miss_run_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = locked_q;
  assign err       = err_q;
  assign err_count = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_checker.sv
`default_nettype none
// ============================================================================
// tb_lfsr_checker : scoreboard bench for lfsr_checker against a sequence model
// Revision        : 1.0
// ============================================================================
module tb_lfsr_checker;

  localparam int         WIDTH   = 5;
  localparam logic [4:0] TAPS    = 5'b10100;
  localparam int         LOSS    = 4;
  localparam int         CNT_W   = 4;
  localparam int         CNT_MAX = (1 << CNT_W) - 1;

  logic             clk      = 1'b0;
  logic             rst      = 1'b1;
  logic             in_bit   = 1'b0;
  logic             in_valid = 1'b0;
  logic             clr_cnt  = 1'b0;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] err_count;

  lfsr_checker #(
    .WIDTH      (WIDTH),
    .TAPS       (TAPS),
    .LOSS_THRESH(LOSS),
    .CNT_W      (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_bit   (in_bit),
    .in_valid (in_valid),
    .clr_cnt  (clr_cnt),
    .locked   (locked),
    .err      (err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit e;
    bit l;
    int c;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Sequences as oldest..newest bit histories; a new bit is the XOR of tapped past bits.
  bit gen_hist[$];
  bit ref_hist[$];
  bit m_locked;
  int m_seed;
  int m_miss;
  int m_cnt;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic bit predict_gen();
    bit p = 1'b0;
    for (int i = 0; i < WIDTH; i++)
      if (TAPS[i]) p ^= gen_hist[gen_hist.size() - 1 - i];
    return p;
  endfunction

  function automatic bit predict_ref();
    bit p = 1'b0;
    for (int i = 0; i < WIDTH; i++)
      if (TAPS[i]) p ^= ref_hist[ref_hist.size() - 1 - i];
    return p;
  endfunction

  task automatic gen_reset();
    gen_hist = {};
    for (int i = 0; i < WIDTH - 1; i++) gen_hist.push_back(1'b0);
    gen_hist.push_back(1'b1);
  endtask

  function automatic bit gen_next();
    bit b = predict_gen();
    gen_hist.push_back(b);
    if (gen_hist.size() > 32) void'(gen_hist.pop_front());
    return b;
  endfunction

  task automatic model_reset();
    m_locked = 1'b0;
    m_seed   = 0;
    m_miss   = 0;
    m_cnt    = 0;
    ref_hist = {};
  endtask

  task automatic model_step(input bit v, input bit b, input bit c);
    exp_t x;
    bit   pred;
    bit   nz;
    x.e = 1'b0;
    if (v) begin
      if (!m_locked) begin
        ref_hist.push_back(b);
        m_seed++;
        if (m_seed == WIDTH) begin
          m_seed = 0;
          nz = 1'b0;
          for (int i = 0; i < WIDTH; i++) nz |= ref_hist[ref_hist.size() - 1 - i];
          m_locked = nz;
        end
      end else begin
        pred = predict_ref();
        ref_hist.push_back(pred);
        if (b != pred) begin
          x.e = 1'b1;
          if (m_cnt < CNT_MAX) m_cnt++;
          m_miss++;
          if (m_miss == LOSS) begin
            m_locked = 1'b0;
            m_miss   = 0;
            m_seed   = 0;
          end
        end else begin
          m_miss = 0;
        end
      end
      if (ref_hist.size() > 32) void'(ref_hist.pop_front());
    end
    if (c) m_cnt = 0;
    x.l = m_locked;
    x.c = m_cnt;
    exp_q.push_back(x);
  endtask

  task automatic drive(input bit v, input bit b, input bit c);
    @(negedge clk);
    in_valid = v;
    in_bit   = b;
    clr_cnt  = c;
    model_step(v, b, c);
  endtask

  task automatic clean(input int n);
    repeat (n) drive(1'b1, gen_next(), 1'b0);
  endtask

  task automatic bad(input int n);
    repeat (n) drive(1'b1, !gen_next(), 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'($urandom), 1'b0);
  endtask

  task automatic drain();
    @(negedge clk);
    in_valid = 1'b0;
    clr_cnt  = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drain", exp_q.size(), 0);
  endtask

  // Monitor: one expectation per driven cycle, sampled just after the edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("err", int'(err), int'(x.e));
        chk("locked", int'(locked), int'(x.l));
        chk("err_count", int'(err_count), x.c);
      end
    end
  end

  initial begin
    bit v;
    bit g;
    model_reset();
    gen_reset();

    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("reset_locked", int'(locked), 0);
      chk("reset_err_count", int'(err_count), 0);
      chk("reset_err", int'(err), 0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Lock, then two clean periods.
    clean(5 + 62);

    // Single injected error.
    bad(1);
    clean(10);

    // Loss of lock and relock.
    drive(1'b0, 1'b0, 1'b1);
    bad(4);
    clean(5);
    clean(10);

    // Near-loss bursts keep lock.
    drive(1'b0, 1'b0, 1'b1);
    bad(3);
    clean(1);
    bad(3);
    clean(10);

    // All-zero seed is rejected, then a fresh stream locks.
    bad(4);
    repeat (WIDTH) drive(1'b1, 1'b0, 1'b0);
    gen_reset();
    clean(30);

    // Gapped valid, then clear coinciding with a mismatch.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      clean(1);
    end
    drive(1'b0, 1'b0, 1'b1);
    bad(1);
    clean(2);
    drive(1'b1, !gen_next(), 1'b1);
    clean(5);

    // Counter saturation.
    drive(1'b0, 1'b0, 1'b1);
    repeat (20) begin
      bad(1);
      clean(1);
    end

    // Random mix of gaps, errors and clears.
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 3) != 0);
      if (v) begin
        g = gen_next();
        if ($urandom_range(0, 7) == 0) g = !g;
      end else begin
        g = 1'($urandom);
      end
      drive(v, g, ($urandom_range(0, 31) == 0));
    end

    // Asynchronous reset between clock edges.
    clean(12);
    bad(1);
    clean(2);
    drain();
    chk("pre_reset_locked", int'(locked), 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_locked", int'(locked), 0);
    chk("async_err_count", int'(err_count), 0);
    chk("async_err", int'(err), 0);
    @(negedge clk);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lfsr_checker.md
# lfsr_checker

Serial PRBS checker: the receive-side counterpart of the 5-bit Fibonacci LFSR generator. It accepts one bit per valid cycle from the generator's serial output, self-seeds a local reference LFSR, and declares lock. It then compares every further bit against the locally predicted bit, reporting mismatches and losing lock on a burst of consecutive errors. It sits at the far end of a link or loopback path for BIST and link-integrity checks.

## Interface
- WIDTH, 5, LFSR length in bits (≥3).
- TAPS, 5'b10100, feedback mask: prediction = XOR-reduce(shadow & TAPS). Default is x^5+x^3+1, period 31.
- LOSS_THRESH, 4, number of consecutive mismatches in CHECK that drops lock (1..15).
- CNT_W, 16, width of the error counter.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_bit  in  1  received serial bit.
- in_valid  in  1  in_bit is meaningful this cycle; idle cycles are ignored.
- clr_cnt  in  1  synchronous clear of err_count.
- locked  out  1  1 while in CHECK.
- err  out  1  one-cycle pulse for each mismatched bit in CHECK.
- err_count  out  CNT_W  saturating total of mismatches since reset or clear.

## Operation
- Reference LFSR (shadow, WIDTH bits):
  - step is shadow <= {shadow[WIDTH-2:0], fb}.
  - fb = ^(shadow & TAPS), which is also the predicted next bit.
- State SEED:
  - Each valid bit shifts in: shadow <= {shadow[WIDTH-2:0], in_bit}. seed_cnt increments.
  - When the WIDTH-th bit is accepted, seed_cnt is cleared.
  - If the resulting shadow is nonzero, go to CHECK.
  - If it is all-zero (invalid LFSR state), stay in SEED and restart seeding.
  - No comparisons are made in SEED, and err never fires there.
- State CHECK:
  - Each valid bit is compared with fb.
  - The shadow always steps with the predicted fb, never with in_bit, so a single bit error does not corrupt the reference.
  - Mismatch: err pulses, err_count increments (saturating at all-ones), miss_run increments.
  - Match: miss_run is cleared.
  - When miss_run reaches LOSS_THRESH, go to SEED with seed_cnt=0 and miss_run=0. The bit that triggered the loss is counted in err_count and pulses err.
- clr_cnt:
  - Sets err_count to 0 next cycle, regardless of state.
  - If it coincides with a counted error, the clear wins and err_count=0.
  - err still pulses.
- in_valid=0 freezes shadow, seed_cnt, miss_run and state.

## Timing
- Reset values: state=SEED, shadow=0, seed_cnt=0, miss_run=0, locked=0, err=0, err_count=0.
- Reset asserted mid-operation returns all of the above immediately (asynchronously).
- All outputs are registered, with latency of 1 clock from the sampling edge.
  - err is high the cycle after the mismatched bit is sampled.
  - locked rises the cycle after the WIDTH-th seed bit is sampled.
  - locked falls the cycle after the LOSS_THRESH-th consecutive mismatch is sampled.
- Lock acquisition: the first bit compared is valid bit WIDTH+1 after entering SEED.
- Valid bits may be back-to-back or gapped arbitrarily; behaviour depends only on the sequence of valid bits.

## Test plan
- Reset and lock:
  - Drive rst=1 for 2 cycles, then a continuous valid stream from the generator seeded 5'b00001 (stream 0,0,1,0,1,...).
  - Required: locked=0, err_count=0 during reset. locked=1 the cycle after the 5th valid bit. err stays 0 for 62 subsequent bits (two periods).
- Single error injection:
  - After lock, invert one bit.
  - Required: exactly one err pulse, err_count=1, locked stays 1, and the following bits match with no further err.
- Loss of lock:
  - After lock, invert 4 consecutive bits.
  - Required: 4 err pulses, err_count=4, locked=0 the cycle after the 4th.
  - Then 5 clean bits: relock, locked=1.
  - Also: 3 inverted bits, 1 clean bit, 3 inverted bits keeps lock, with err_count=6.
- All-zero seed:
  - Send 5 zeros, then a correct stream.
  - Required: locked stays 0 after the zeros; it locks 5 valid bits into the correct stream.
- Gapped valid and clear:
  - Insert random in_valid=0 gaps in the stream.
  - Required: no err. clr_cnt asserted in the same cycle as a mismatch gives err=1 and err_count=0.
- Saturation and async reset:
  - With CNT_W=4, force 20 single errors, each separated by a clean bit.
  - Required: err_count holds at 15.
  - Assert rst between clock edges: locked=0 and err_count=0 without waiting for a clock edge.
